// File: rtl/hello_scroll.sv
// Scrolls "HELLO" right-to-left across four active-low 7-segment digits.
// One symbol enters HEX0 per scroll tick; SW[1] pauses everything, SW[0] resets.
module hello_scroll #(
  parameter int         TICK_DIV = 50000000,
  parameter logic [6:0] BLANK    = 7'b1111111
) (
  input  logic       CLOCK_50,
  input  logic [1:0] SW,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3
);

  localparam logic [6:0]  SEG_H    = 7'b0001001;
  localparam logic [6:0]  SEG_E    = 7'b0000110;
  localparam logic [6:0]  SEG_L    = 7'b1000111;
  localparam logic [6:0]  SEG_O    = 7'b1000000;
  localparam logic [25:0] DIV_LAST = 26'(TICK_DIV - 1);

  typedef enum logic [2:0] {S0, S1, S2, S3, S4, S5, S6, S7} state_t;

  logic        rst_n;
  logic        run;
  logic        tick;
  state_t      state_q;
  logic [25:0] div_cnt_q;
  logic [25:0] div_cnt_d;
  logic [6:0]  hex0_q, hex1_q, hex2_q, hex3_q;

  assign rst_n = SW[0];
  assign run   = SW[1];

  // A pause on the terminal count suppresses the tick and holds the count there.
  assign tick = run && (div_cnt_q == DIV_LAST);

  always_comb begin
    div_cnt_d = div_cnt_q;
    if (tick) begin
      div_cnt_d = '0;
    end else if (run) begin
      div_cnt_d = div_cnt_q + 26'd1;
    end
  end

  function automatic logic [6:0] sym_code(input state_t s);
    logic [6:0] code;
    case (s)
      S0:      code = SEG_H;
      S1:      code = SEG_E;
      S2:      code = SEG_L;
      S3:      code = SEG_L;
      S4:      code = SEG_O;
      default: code = BLANK;
    endcase
    return code;
  endfunction

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S0;
      div_cnt_q <= '0;
      hex0_q    <= BLANK;
      hex1_q    <= BLANK;
      hex2_q    <= BLANK;
      hex3_q    <= BLANK;
    end else begin
      div_cnt_q <= div_cnt_d;
      if (tick) begin
        hex3_q  <= hex2_q;
        hex2_q  <= hex1_q;
        hex1_q  <= hex0_q;
        hex0_q  <= sym_code(state_q);
        // 3-bit increment wraps S7 back to S0.
        state_q <= state_t'(state_q + 3'd1);
      end
    end
  end

  assign HEX0 = hex0_q;
  assign HEX1 = hex1_q;
  assign HEX2 = hex2_q;
  assign HEX3 = hex3_q;

endmodule

// File: tb/tb_hello_scroll.sv
// Directed bench for hello_scroll: scrolling, wrap, pause, mid-frame reset,
// pause on the terminal count, and the TICK_DIV = 1 case.
module tb_hello_scroll;

  localparam logic [6:0] H = 7'b0001001;
  localparam logic [6:0] E = 7'b0000110;
  localparam logic [6:0] L = 7'b1000111;
  localparam logic [6:0] O = 7'b1000000;
  localparam logic [6:0] B = 7'b1111111;

  logic       clk;
  logic [1:0] sw;
  logic [1:0] sw1;
  logic [6:0] h0, h1, h2, h3;
  logic [6:0] g0, g1, g2, g3;
  logic [27:0] disp;
  logic [27:0] disp1;
  int checks;
  int failures;

  hello_scroll #(.TICK_DIV(4)) u_dut (
    .CLOCK_50(clk), .SW(sw), .HEX0(h0), .HEX1(h1), .HEX2(h2), .HEX3(h3)
  );

  hello_scroll #(.TICK_DIV(1)) u_dut1 (
    .CLOCK_50(clk), .SW(sw1), .HEX0(g0), .HEX1(g1), .HEX2(g2), .HEX3(g3)
  );

  assign disp  = {h3, h2, h1, h0};
  assign disp1 = {g3, g2, g1, g0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    sw  = 2'b00;
    sw1 = 2'b00;
    step(3);
    checks++;
    if (disp !== {B, B, B, B}) begin
      failures++;
      $display("FAIL reset_blank got=%h want=%h", disp, {B, B, B, B});
    end
    checks++;
    if (disp1 !== {B, B, B, B}) begin
      failures++;
      $display("FAIL reset_blank_div1 got=%h want=%h", disp1, {B, B, B, B});
    end
  endtask

  task automatic test_scroll;
    logic [27:0] exp_tbl [9];
    logic [27:0] prev;
    exp_tbl[0] = {B, B, B, H};
    exp_tbl[1] = {B, B, H, E};
    exp_tbl[2] = {B, H, E, L};
    exp_tbl[3] = {H, E, L, L};
    exp_tbl[4] = {E, L, L, O};
    exp_tbl[5] = {L, L, O, B};
    exp_tbl[6] = {L, O, B, B};
    exp_tbl[7] = {O, B, B, B};
    exp_tbl[8] = {B, B, B, H};
    prev = {B, B, B, B};
    sw = 2'b11;
    for (int t = 0; t < 9; t++) begin
      step(3);
      checks++;
      if (disp !== prev) begin
        failures++;
        $display("FAIL scroll_hold tick=%0d got=%h want=%h", t + 1, disp, prev);
      end
      step(1);
      checks++;
      if (disp !== exp_tbl[t]) begin
        failures++;
        $display("FAIL scroll_tick tick=%0d got=%h want=%h", t + 1, disp, exp_tbl[t]);
      end
      prev = exp_tbl[t];
    end
  endtask

  task automatic test_pause;
    step(2);
    sw = 2'b01;
    for (int i = 0; i < 10; i++) begin
      step(1);
      checks++;
      if (disp !== {B, B, B, H}) begin
        failures++;
        $display("FAIL pause_frozen cyc=%0d got=%h want=%h", i, disp, {B, B, B, H});
      end
    end
    sw = 2'b11;
    step(1);
    checks++;
    if (disp !== {B, B, B, H}) begin
      failures++;
      $display("FAIL pause_resume_early got=%h want=%h", disp, {B, B, B, H});
    end
    step(1);
    checks++;
    if (disp !== {B, B, H, E}) begin
      failures++;
      $display("FAIL pause_resume_tick got=%h want=%h", disp, {B, B, H, E});
    end
  endtask

  task automatic test_reset_midframe;
    step(4);
    checks++;
    if (disp !== {B, H, E, L}) begin
      failures++;
      $display("FAIL midframe_pre got=%h want=%h", disp, {B, H, E, L});
    end
    step(3);
    #2;
    sw = 2'b10;
    #1;
    checks++;
    if (disp !== {B, B, B, B}) begin
      failures++;
      $display("FAIL midframe_async got=%h want=%h", disp, {B, B, B, B});
    end
    step(3);
    checks++;
    if (disp !== {B, B, B, B}) begin
      failures++;
      $display("FAIL midframe_held got=%h want=%h", disp, {B, B, B, B});
    end
    sw = 2'b11;
    step(3);
    checks++;
    if (disp !== {B, B, B, B}) begin
      failures++;
      $display("FAIL midframe_restart_early got=%h want=%h", disp, {B, B, B, B});
    end
    step(1);
    checks++;
    if (disp !== {B, B, B, H}) begin
      failures++;
      $display("FAIL midframe_restart_tick got=%h want=%h", disp, {B, B, B, H});
    end
  endtask

  task automatic test_drop_at_last;
    step(3);
    sw = 2'b01;
    step(1);
    checks++;
    if (disp !== {B, B, B, H}) begin
      failures++;
      $display("FAIL drop_last_noshift got=%h want=%h", disp, {B, B, B, H});
    end
    step(2);
    checks++;
    if (disp !== {B, B, B, H}) begin
      failures++;
      $display("FAIL drop_last_hold got=%h want=%h", disp, {B, B, B, H});
    end
    sw = 2'b11;
    step(1);
    checks++;
    if (disp !== {B, B, H, E}) begin
      failures++;
      $display("FAIL drop_last_resume got=%h want=%h", disp, {B, B, H, E});
    end
  endtask

  task automatic test_div1;
    logic [27:0] exp_tbl [9];
    logic [27:0] first;
    exp_tbl[0] = {B, B, B, H};
    exp_tbl[1] = {B, B, H, E};
    exp_tbl[2] = {B, H, E, L};
    exp_tbl[3] = {H, E, L, L};
    exp_tbl[4] = {E, L, L, O};
    exp_tbl[5] = {L, L, O, B};
    exp_tbl[6] = {L, O, B, B};
    exp_tbl[7] = {O, B, B, B};
    exp_tbl[8] = {B, B, B, H};
    first = '0;
    sw1 = 2'b11;
    for (int c = 0; c < 9; c++) begin
      step(1);
      if (c == 0) first = disp1;
      checks++;
      if (disp1 !== exp_tbl[c]) begin
        failures++;
        $display("FAIL div1_cycle cyc=%0d got=%h want=%h", c + 1, disp1, exp_tbl[c]);
      end
    end
    checks++;
    if (disp1 !== first) begin
      failures++;
      $display("FAIL div1_period got=%h want=%h", disp1, first);
    end
    sw1 = 2'b01;
    step(3);
    checks++;
    if (disp1 !== {B, B, B, H}) begin
      failures++;
      $display("FAIL div1_pause got=%h want=%h", disp1, {B, B, B, H});
    end
    sw1 = 2'b11;
    step(1);
    checks++;
    if (disp1 !== {B, B, H, E}) begin
      failures++;
      $display("FAIL div1_resume got=%h want=%h", disp1, {B, B, H, E});
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    sw       = 2'b00;
    sw1      = 2'b00;
    test_reset;
    test_scroll;
    test_pause;
    test_reset_midframe;
    test_drop_at_last;
    test_div1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
